// File: rtl/keccak_pkg.sv
// Shared constants and state type for the Keccak message padder.
// Original-Keccak multi-rate padding: 0x01 after the message, 0x80 in the last rate byte.
package keccak_pkg;

  localparam int KECCAK_R = 1088;
  localparam int KECCAK_W = 64;
  localparam int WORDS    = KECCAK_R / KECCAK_W;
  localparam int BYTES    = KECCAK_R / 8;

  localparam logic [7:0] PAD_FIRST = 8'h01;
  localparam logic [7:0] PAD_LAST  = 8'h80;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_EXTRA = 2'd1,
    ST_OUT   = 2'd2
  } pad_state_e;

endpackage

// File: rtl/keccak_word_pad.sv
// Masks the final message word and drops the 0x01 pad byte into its first free byte.
// A full final word is passed through untouched with pad_placed low.
module keccak_word_pad
  import keccak_pkg::*;
#(
  parameter  int W  = 64,
  localparam int NB = W / 8,
  localparam int BW = $clog2(NB) + 1
) (
  input  logic [W-1:0]  word,
  input  logic [BW-1:0] bytes,
  input  logic          last,
  output logic [W-1:0]  padded,
  output logic          pad_placed
);

  always_comb begin
    padded     = word;
    pad_placed = 1'b0;
    if (last && (bytes < BW'(NB))) begin
      pad_placed = 1'b1;
      for (int k = 0; k < NB; k++) begin
        if (BW'(k) == bytes) begin
          padded[8*k +: 8] = PAD_FIRST;
        end else if (BW'(k) > bytes) begin
          padded[8*k +: 8] = 8'h00;
        end
      end
    end
  end

endmodule

// File: rtl/keccak_msg_padder.sv
// Packs message words into rate-sized blocks and applies Keccak multi-rate padding.
// A message whose last word exactly fills a block gets a trailing padding-only block.
module keccak_msg_padder
  import keccak_pkg::*;
#(
  parameter int R  = KECCAK_R,
  parameter int W  = KECCAK_W,
  parameter int CW = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [W-1:0]         i_data,
  input  logic                 i_last,
  input  logic [$clog2(W/8):0] i_bytes,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [R-1:0]         o_block,
  output logic                 o_last,
  output logic [CW-1:0]        o_block_cnt
);

  // state    | meaning
  // ST_FILL  | accepting words into the block buffer
  // ST_EXTRA | building the padding-only block after a pad-less full block
  // ST_OUT   | block presented, waiting for the consumer

  localparam int NWORDS = R / W;
  localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  pad_state_e                  state_q, state_d;
  logic [NWORDS-1:0][W-1:0]    blk_q, blk_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic                        last_q, last_d;
  logic                        extra_q, extra_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [CW-1:0]               cnt_inc;
  logic [W-1:0]                padded;
  logic                        pad_placed;
  logic                        accept;

  keccak_word_pad #(.W(W)) u_word_pad (
    .word       (i_data),
    .bytes      (i_bytes),
    .last       (i_last),
    .padded     (padded),
    .pad_placed (pad_placed)
  );

  assign accept  = i_valid && o_ready;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  assign o_valid     = (state_q == ST_OUT);
  assign o_block     = blk_q;
  assign o_last      = last_q;
  assign o_block_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    idx_d   = idx_q;
    last_d  = last_q;
    extra_d = extra_q;
    cnt_d   = cnt_q;
    o_ready = 1'b0;

    unique case (state_q)
      ST_FILL: begin
        // Gated by reset so the source sees not-ready while reset is held.
        o_ready = i_rst_n;
        if (accept) begin
          blk_d[idx_q] = padded;
          idx_d        = idx_q + 1'b1;
          last_d       = 1'b0;
          if (i_last) begin
            for (int j = 0; j < NWORDS; j++) begin
              if (IW'(j) > idx_q) blk_d[j] = '0;
            end
            if (!pad_placed && (idx_q == LAST_IDX)) begin
              extra_d = 1'b1;
            end else begin
              if (!pad_placed) blk_d[idx_q + 1'b1][7:0] = PAD_FIRST;
              blk_d[NWORDS-1][W-1 -: 8] = blk_d[NWORDS-1][W-1 -: 8] | PAD_LAST;
              last_d = 1'b1;
            end
          end
          if (i_last || (idx_q == LAST_IDX)) begin
            idx_d   = '0;
            cnt_d   = cnt_inc;
            state_d = ST_OUT;
          end
        end
      end

      ST_OUT: begin
        if (i_ready) begin
          if (extra_q) begin
            state_d = ST_EXTRA;
          end else begin
            if (last_q) cnt_d = '0;
            state_d = ST_FILL;
          end
        end
      end

      ST_EXTRA: begin
        blk_d          = '0;
        blk_d[0][7:0]  = PAD_FIRST;
        blk_d[NWORDS-1][W-1 -: 8] = blk_d[NWORDS-1][W-1 -: 8] | PAD_LAST;
        last_d  = 1'b1;
        extra_d = 1'b0;
        cnt_d   = cnt_inc;
        state_d = ST_OUT;
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_FILL;
      blk_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      extra_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      extra_q <= extra_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
